// File: rtl/pixel_stream_packer_if.sv
// Pixel-side and AXI4-Stream-side bundles for pixel_stream_packer.
// pix_if carries per-channel pixels upstream; axis_if carries packed video beats downstream.
interface pix_if #(parameter int CH_W = 8);
    logic [CH_W-1:0] r, g, b;
    logic            pix_valid;
    logic            pix_ready;
    logic            restart;
    modport master (output r, g, b, pix_valid, restart, input pix_ready);
    modport slave  (input r, g, b, pix_valid, restart, output pix_ready);
endinterface

interface axis_if #(parameter int DW = 24);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;
    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: packs r/g/b into AXI4-Stream beats tagged SOF/EOL from x/y counters,
// using an output register plus a skid register so pix_ready stays registered at full rate.
module pixel_stream_packer #(
    parameter int CH_W   = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ORDER  = 0
) (
    input  logic   aclk,
    input  logic   aresetn,
    pix_if.slave   pix,
    axis_if.master m_axis,
    output logic   frame_done
);
    localparam int DW = 3 * CH_W;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
        logic          eof;
    } entry_t;

    entry_t        out_q, out_d, skd_q, skd_d, new_e;
    logic          out_v_q, out_v_d, skd_v_q, skd_v_d, fd_q, fd_d;
    logic [XW-1:0] x_q, x_d, cx;
    logic [YW-1:0] y_q, y_d, cy;
    logic          acc, xfer, out_free;

    always_comb begin
        acc        = pix.pix_valid & ~skd_v_q;
        xfer       = out_v_q & m_axis.tready;
        out_free   = ~out_v_q | m_axis.tready;
        // restart retags the pixel accepted in the same cycle as (0,0)
        cx         = pix.restart ? '0 : x_q;
        cy         = pix.restart ? '0 : y_q;
        new_e.data = (ORDER == 1) ? {pix.b, pix.g, pix.r} : {pix.r, pix.g, pix.b};
        new_e.user = (cx == '0) && (cy == '0);
        new_e.last = cx == XW'(WIDTH - 1);
        new_e.eof  = new_e.last && (cy == YW'(HEIGHT - 1));
        x_d        = acc ? (new_e.last ? '0 : cx + 1'b1) : cx;
        y_d        = acc && new_e.last ? (new_e.eof ? '0 : cy + 1'b1) : cy;
        out_d      = out_free ? (skd_v_q ? skd_q : (acc ? new_e : out_q)) : out_q;
        out_v_d    = skd_v_q | acc | (out_v_q & ~m_axis.tready);
        skd_d      = (acc & ~out_free) ? new_e : skd_q;
        skd_v_d    = skd_v_q ? ~m_axis.tready : (acc & ~out_free);
        fd_d       = xfer & out_q.eof;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q   <= '0;
            skd_q   <= '0;
            out_v_q <= 1'b0;
            skd_v_q <= 1'b0;
            fd_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            out_q   <= out_d;
            skd_q   <= skd_d;
            out_v_q <= out_v_d;
            skd_v_q <= skd_v_d;
            fd_q    <= fd_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign pix.pix_ready = ~skd_v_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tvalid = out_v_q;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tlast  = out_q.last;
    assign frame_done    = fd_q;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb_pixel_stream_packer: scoreboard + table-driven bench for a 4x2 frame, with an ORDER=1 twin
// sharing the same stimulus so both channel orderings are checked on every beat.
module tb_pixel_stream_packer;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    pix_if  #(.CH_W(8)) pif ();
    pix_if  #(.CH_W(8)) pif1 ();
    axis_if #(.DW(24))  ax0 ();
    axis_if #(.DW(24))  ax1 ();
    logic fd0, fd1;

    assign pif1.r         = pif.r;
    assign pif1.g         = pif.g;
    assign pif1.b         = pif.b;
    assign pif1.pix_valid = pif.pix_valid;
    assign pif1.restart   = pif.restart;
    assign ax1.tready     = ax0.tready;

    pixel_stream_packer #(.CH_W(8), .WIDTH(4), .HEIGHT(2), .ORDER(0)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .pix(pif), .m_axis(ax0), .frame_done(fd0));
    pixel_stream_packer #(.CH_W(8), .WIDTH(4), .HEIGHT(2), .ORDER(1)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .pix(pif1), .m_axis(ax1), .frame_done(fd1));

    typedef struct {
        logic [23:0] d0, d1;
        logic        user, last, eof;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [7:0]  r, g, b;
        logic [23:0] rgb, bgr;
    } vec_t;
    vec_t tbl[4];

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pif.r = r;
        pif.g = g;
        pif.b = b;
    endtask

    // Reference model: independent x/y counters over a 4x2 frame, updated on observed accepts
    int   ex = 0, ey = 0, cx, cy;
    logic exp_fd = 1'b0;
    exp_t e;
    always @(negedge aclk) begin
        if (!aresetn) begin
            sbq.delete();
            ex = 0;
            ey = 0;
            exp_fd = 1'b0;
        end else begin
            chk("frame_done", fd0, exp_fd);
            exp_fd = 1'b0;
            if (ax0.tvalid && ax0.tready) begin
                chk("beat_expected", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("tdata", ax0.tdata, e.d0);
                    chk("tdata_order1", ax1.tdata, e.d1);
                    chk("tuser_tlast", {ax0.tuser, ax0.tlast}, {e.user, e.last});
                    exp_fd = e.eof;
                end
            end
            if (pif.pix_valid && pif.pix_ready) begin
                cx = pif.restart ? 0 : ex;
                cy = pif.restart ? 0 : ey;
                e.d0 = {pif.r, pif.g, pif.b};
                e.d1 = {pif.b, pif.g, pif.r};
                e.user = (cx == 0) && (cy == 0);
                e.last = cx == 3;
                e.eof = e.last && (cy == 1);
                sbq.push_back(e);
                ex = e.last ? 0 : cx + 1;
                ey = e.last ? (e.eof ? 0 : cy + 1) : cy;
            end else if (pif.restart) begin
                ex = 0;
                ey = 0;
            end
        end
    end

    logic [23:0] hold, nxt;

    initial begin
        tbl[0] = '{8'h11, 8'h22, 8'h33, 24'h112233, 24'h332211};
        tbl[1] = '{8'hff, 8'h00, 8'h80, 24'hff0080, 24'h8000ff};
        tbl[2] = '{8'h01, 8'h02, 8'h03, 24'h010203, 24'h030201};
        tbl[3] = '{8'ha5, 8'h5a, 8'hc3, 24'ha55ac3, 24'hc35aa5};
        pif.pix_valid = 1'b0;
        pif.restart = 1'b0;
        set_pix(8'h0, 8'h0, 8'h0);
        ax0.tready = 1'b0;
        #12;
        chk("rst_tvalid", ax0.tvalid, 0);
        chk("rst_pix_ready", pif.pix_ready, 1);
        chk("rst_tdata", ax0.tdata, 0);
        chk("rst_tuser_tlast", {ax0.tuser, ax0.tlast}, 0);
        chk("rst_frame_done", fd0, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // One full frame back-to-back at full rate
        ax0.tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_pix(8'(i), 8'(i + 16), 8'(i + 32));
            pif.pix_valid = 1'b1;
            step();
            if (i == 0) chk("latency1_tvalid", ax0.tvalid, 1);
        end
        pif.pix_valid = 1'b0;
        repeat (3) step();

        // Channel ordering, one pixel at a time
        for (int i = 0; i < 4; i++) begin
            set_pix(tbl[i].r, tbl[i].g, tbl[i].b);
            pif.pix_valid = 1'b1;
            step();
            pif.pix_valid = 1'b0;
            chk("order0_tdata", ax0.tdata, tbl[i].rgb);
            chk("order1_tdata", ax1.tdata, tbl[i].bgr);
            step();
        end

        // Advance to (2,1), then restart with accept there
        for (int i = 0; i < 2; i++) begin
            set_pix(8'h40, 8'(i), 8'h41);
            pif.pix_valid = 1'b1;
            step();
        end
        pif.restart = 1'b1;
        set_pix(8'h50, 8'h51, 8'h52);
        step();
        pif.restart = 1'b0;
        chk("restart_tuser", ax0.tuser, 1);
        for (int k = 1; k <= 3; k++) begin
            set_pix(8'h60, 8'(k), 8'h61);
            step();
            chk("restart_tlast", ax0.tlast, k == 3);
        end
        pif.pix_valid = 1'b0;
        step();

        // Back-pressure: fill OUT then SKD
        ax0.tready = 1'b0;
        set_pix(8'h71, 8'h72, 8'h73);
        pif.pix_valid = 1'b1;
        step();
        chk("bp_tvalid", ax0.tvalid, 1);
        chk("bp_ready_after_1", pif.pix_ready, 1);
        hold = ax0.tdata;
        chk("bp_out_data", hold, 24'h717273);
        set_pix(8'h81, 8'h82, 8'h83);
        step();
        chk("bp_ready_after_2", pif.pix_ready, 0);
        chk("bp_stable_1", ax0.tdata, hold);
        set_pix(8'h91, 8'h92, 8'h93);
        step();
        chk("bp_ready_held", pif.pix_ready, 0);
        chk("bp_stable_2", ax0.tdata, hold);
        ax0.tready = 1'b1;
        step();
        nxt = ax0.tdata;
        chk("bp_ready_rise", pif.pix_ready, 1);
        chk("bp_skid_to_out", nxt, 24'h818283);
        step();
        pif.pix_valid = 1'b0;
        repeat (3) step();

        // Reset with SKD full
        ax0.tready = 1'b0;
        set_pix(8'ha1, 8'ha2, 8'ha3);
        pif.pix_valid = 1'b1;
        step();
        set_pix(8'hb1, 8'hb2, 8'hb3);
        step();
        chk("rst_mid_skd_full", pif.pix_ready, 0);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_tvalid", ax0.tvalid, 0);
        chk("rst_mid_pix_ready", pif.pix_ready, 1);
        pif.pix_valid = 1'b0;
        step();
        aresetn = 1'b1;
        ax0.tready = 1'b1;
        set_pix(8'hc1, 8'hc2, 8'hc3);
        pif.pix_valid = 1'b1;
        step();
        pif.pix_valid = 1'b0;
        chk("post_rst_tvalid", ax0.tvalid, 1);
        chk("post_rst_tuser", ax0.tuser, 1);
        step();

        // Random valid/ready traffic
        for (int i = 0; i < 10000; i++) begin
            pif.pix_valid = $urandom_range(0, 3) != 0;
            ax0.tready = $urandom_range(0, 2) != 0;
            set_pix(8'($urandom), 8'($urandom), 8'($urandom));
            step();
        end

        pif.pix_valid = 1'b0;
        ax0.tready = 1'b1;
        for (int i = 0; i < 100 && sbq.size() != 0; i++) step();
        chk("drain_empty", sbq.size(), 0);
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
